hssi_tc_mailbox_ctrl: RTL and testbench
=======================================

// Module: hssi_tc_mailbox_ctrl
// PURPOSE
//  Mailbox controller in the HSSI KPI AFU: turns host mailbox writes (CMD/ADDRESS/RDDATA/WRDATA
//  at offsets 0x0/0x4/0x8/0xC of the mailbox window) into single Avalon-MM accesses on the
//  traffic-controller register bus (TG_*, TM_*, LOOPBACK_EN). One transaction in flight at a time.
//  A timeout guards against a hung traffic controller.
// PARAMETERS
//  TC_ADDR_W       16    traffic-controller word address width
//  TIMEOUT_CYCLES  1024  cycles from issue to forced completion; must be >= 2
// PORTS
//  clk              in   1          AFU clock
//  rst              in   1          async active-high reset
//  mb_wr            in   1          host mailbox write strobe
//  mb_wr_offset     in   4          byte offset of write (0x0,0x4,0x8,0xC)
//  mb_wr_data       in   32         host write data
//  mb_rd            in   1          host mailbox read strobe
//  mb_rd_offset     in   4          byte offset of read
//  mb_rd_data       out  32         read data, valid with mb_rd_valid
//  mb_rd_valid      out  1          one-cycle pulse, 1 cycle after mb_rd
//  tc_address       out  TC_ADDR_W  TC register address
//  tc_read          out  1          AVMM read request
//  tc_write         out  1          AVMM write request
//  tc_writedata     out  32         AVMM write data
//  tc_waitrequest   in   1          AVMM stall
//  tc_readdata      in   32         AVMM read data
//  tc_readdatavalid in   1          AVMM read data valid
// BEHAVIOUR
//  Reset: all outputs 0; ADDRESS/WRDATA/RDDATA regs 0; ack=0, busy=0, err=0; FSM IDLE.
//  CMD reg read: [1:0] last cmd, [2] ack, [3] busy, [4] timeout err; [31:5] read 0.
//  ADDRESS/WRDATA: host R/W anytime; shadowed into tc_address/tc_writedata at command start,
//   so mid-transaction host writes do not change the bus. ADDRESS truncated to TC_ADDR_W bits.
//  RDDATA: read-only; host writes ignored. Unmapped offsets read 0, writes ignored.
//  Write to CMD when IDLE: 1=RD, 2=WR -> clear ack and err, set busy, start. 0 (NOOP) -> clear ack
//   only. 3 -> treated as NOOP. Write to CMD while busy: ignored entirely.
//  FSM: IDLE -> RD_REQ (tc_read=1) | WR_REQ (tc_write=1), asserted the cycle after the CMD write.
//   RD_REQ: hold tc_read until cycle with tc_waitrequest=0 -> RD_WAIT (tc_read=0).
//    readdatavalid in the accept cycle is also taken (RD_WAIT skipped -> DONE).
//   RD_WAIT: on tc_readdatavalid capture tc_readdata into RDDATA -> DONE.
//   WR_REQ: hold tc_write/data until tc_waitrequest=0 -> DONE.
//   DONE (1 cycle): busy=0, ack=1 -> IDLE.
//  Timeout: counter clears at start, +1 per cycle in RD_REQ/RD_WAIT/WR_REQ; at TIMEOUT_CYCLES
//   drop tc_read/tc_write, err=1, RDDATA=32'hFFFF_FFFF if read, -> DONE (ack=1 also set).
//   Late tc_readdatavalid after timeout ignored in IDLE.
//  mb_rd: mb_rd_data/mb_rd_valid registered, 1-cycle latency; reads never stall.
//   Same-cycle mb_wr and mb_rd to same offset: read returns pre-write value.
//  Host reads of CMD in DONE cycle see ack=0; ack visible from the following cycle.
//  Async reset mid-transaction: bus requests drop immediately; no transaction completion reported.
// TESTING
//  WRDATA=0x10, ADDR=0x000, CMD=2; waitrequest high 3 cycles -> tc_write held 4 cycles, addr 0x000,
//   data 0x10; then CMD reads ack=1, busy=0, err=0.
//  ADDR=0x101, CMD=1; readdatavalid with 0x55 5 cycles after accept -> RDDATA=0x55, ack=1.
//  CMD=1 with waitrequest stuck high, TIMEOUT_CYCLES=16 -> tc_read drops after 16 cycles,
//   err=1, ack=1, RDDATA=0xFFFF_FFFF; next CMD=2 clears err.
//  While busy: write CMD=2, ADDR=0x200 -> in-flight address unchanged, no second access;
//   after ack ADDR reads 0x200.
//  Assert rst during WR_REQ -> tc_write=0 same cycle, CMD reads 0 after reset, no spurious access.
//  CMD=0 after completed op -> ack cleared, no bus activity; CMD=3 -> no bus activity.

Source files
------------

// File: rtl/hssi_tc_mailbox_ctrl.sv
// hssi_tc_mailbox_ctrl: host mailbox to traffic-controller AVMM bridge, one access in flight with timeout
module hssi_tc_mailbox_ctrl #(
  parameter int TC_ADDR_W = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mb_wr,
  input  logic [3:0]           mb_wr_offset,
  input  logic [31:0]          mb_wr_data,
  input  logic                 mb_rd,
  input  logic [3:0]           mb_rd_offset,
  output logic [31:0]          mb_rd_data,
  output logic                 mb_rd_valid,
  output logic [TC_ADDR_W-1:0] tc_address,
  output logic                 tc_read,
  output logic                 tc_write,
  output logic [31:0]          tc_writedata,
  input  logic                 tc_waitrequest,
  input  logic [31:0]          tc_readdata,
  input  logic                 tc_readdatavalid
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;
  state_t               state;
  logic [1:0]           last;
  logic                 ack, busy, err;
  logic [TC_ADDR_W-1:0] addr;
  logic [31:0]          wrdata, rddata, rd_mux;
  logic [CW-1:0]        cnt;
  logic                 cmd_wr, go, timeout;
  always_comb begin
    cmd_wr  = mb_wr && mb_wr_offset == 4'h0 && state == IDLE;
    go      = mb_wr_data[1:0] == 2'd1 || mb_wr_data[1:0] == 2'd2;
    timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    rd_mux  = mb_rd_offset == 4'h0 ? {27'b0, err, busy, ack, last} :
              mb_rd_offset == 4'h4 ? 32'(addr) :
              mb_rd_offset == 4'h8 ? rddata :
              mb_rd_offset == 4'hC ? wrdata : 32'h0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= '0;
      ack          <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
      addr         <= '0;
      wrdata       <= '0;
      rddata       <= '0;
      cnt          <= '0;
      mb_rd_data   <= '0;
      mb_rd_valid  <= 1'b0;
      tc_address   <= '0;
      tc_read      <= 1'b0;
      tc_write     <= 1'b0;
      tc_writedata <= '0;
    end else begin
      // reads sample registers before this cycle's writes land
      mb_rd_valid <= mb_rd;
      mb_rd_data  <= mb_rd ? rd_mux : 32'h0;
      if (mb_wr && mb_wr_offset == 4'h4) addr <= mb_wr_data[TC_ADDR_W-1:0];
      if (mb_wr && mb_wr_offset == 4'hC) wrdata <= mb_wr_data;
      case (state)
        IDLE: if (cmd_wr) begin
          last <= mb_wr_data[1:0];
          ack  <= 1'b0;
          if (go) begin
            err          <= 1'b0;
            busy         <= 1'b1;
            cnt          <= '0;
            tc_address   <= addr;
            tc_writedata <= wrdata;
            tc_read      <= mb_wr_data[1:0] == 2'd1;
            tc_write     <= mb_wr_data[1:0] == 2'd2;
            state        <= mb_wr_data[1:0] == 2'd1 ? RD_REQ : WR_REQ;
          end
        end
        RD_REQ: begin
          cnt <= cnt + 1'b1;
          if (!tc_waitrequest) begin
            tc_read <= 1'b0;
            if (tc_readdatavalid) rddata <= tc_readdata;
            state <= tc_readdatavalid ? DONE : RD_WAIT;
          end else if (timeout) begin
            tc_read <= 1'b0;
            err     <= 1'b1;
            rddata  <= 32'hFFFF_FFFF;
            state   <= DONE;
          end
        end
        RD_WAIT: begin
          cnt <= cnt + 1'b1;
          if (tc_readdatavalid) begin
            rddata <= tc_readdata;
            state  <= DONE;
          end else if (timeout) begin
            err    <= 1'b1;
            rddata <= 32'hFFFF_FFFF;
            state  <= DONE;
          end
        end
        WR_REQ: begin
          cnt <= cnt + 1'b1;
          if (!tc_waitrequest || timeout) begin
            tc_write <= 1'b0;
            err      <= tc_waitrequest;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          ack   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hssi_tc_mailbox_ctrl.sv
// tb_hssi_tc_mailbox_ctrl: register table plus transaction sequences against an AVMM slave model
module tb_hssi_tc_mailbox_ctrl;
  localparam int AW = 16;
  localparam int TO = 16;
  logic          clk = 1'b0, rst = 1'b1;
  logic          mb_wr = 1'b0, mb_rd = 1'b0;
  logic [3:0]    mb_wr_offset = '0, mb_rd_offset = '0;
  logic [31:0]   mb_wr_data = '0, mb_rd_data;
  logic          mb_rd_valid;
  logic [AW-1:0] tc_address;
  logic          tc_read, tc_write;
  logic [31:0]   tc_writedata;
  logic          tc_waitrequest = 1'b0, tc_readdatavalid = 1'b0;
  logic [31:0]   tc_readdata = '0;

  hssi_tc_mailbox_ctrl #(.TC_ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .mb_wr(mb_wr), .mb_wr_offset(mb_wr_offset), .mb_wr_data(mb_wr_data),
    .mb_rd(mb_rd), .mb_rd_offset(mb_rd_offset), .mb_rd_data(mb_rd_data), .mb_rd_valid(mb_rd_valid),
    .tc_address(tc_address), .tc_read(tc_read), .tc_write(tc_write), .tc_writedata(tc_writedata),
    .tc_waitrequest(tc_waitrequest), .tc_readdata(tc_readdata), .tc_readdatavalid(tc_readdatavalid)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] exp; string name;} rexp_t;
  typedef struct {logic wr; logic [AW-1:0] addr; logic [31:0] data;} bus_t;
  rexp_t rd_q[$];
  bus_t  bus_q[$];

  int          wr_stall = 0, rd_lat = 0, stall_cnt = 0, rd_cd = 0, wr_hi = 0, rd_hi = 0;
  bit          stuck = 1'b0;
  logic [31:0] rd_val = '0;

  // slave model and output monitors, all sampled mid-cycle
  always @(negedge clk) begin : mon
    rexp_t e;
    bus_t  b;
    if (mb_rd_valid) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rd_valid: got data %h expected no read", mb_rd_data);
      end else begin
        e = rd_q.pop_front();
        chk(e.name, mb_rd_data, e.exp);
      end
    end
    if (tc_write) wr_hi++;
    if (tc_read) rd_hi++;
    tc_readdatavalid = 1'b0;
    if (rst) begin
      stall_cnt = 0;
      rd_cd = 0;
      tc_waitrequest = 1'b0;
    end else begin
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          tc_readdatavalid = 1'b1;
          tc_readdata = rd_val;
        end
      end
      if (tc_read || tc_write) begin
        if (stuck || stall_cnt < wr_stall) begin
          tc_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          tc_waitrequest = 1'b0;
          stall_cnt = 0;
          if (bus_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_access: got rd=%0b wr=%0b addr %h expected none", tc_read, tc_write, tc_address);
          end else begin
            b = bus_q.pop_front();
            chk("bus_kind", 32'(tc_write), 32'(b.wr));
            chk("bus_addr", 32'(tc_address), 32'(b.addr));
            if (b.wr) chk("bus_data", tc_writedata, b.data);
          end
          if (tc_read) begin
            if (rd_lat == 0) begin
              tc_readdatavalid = 1'b1;
              tc_readdata = rd_val;
            end else rd_cd = rd_lat;
          end
        end
      end else begin
        tc_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic wr(input logic [3:0] o, input logic [31:0] d);
    mb_wr = 1'b1;
    mb_wr_offset = o;
    mb_wr_data = d;
    @(posedge clk); #1;
    mb_wr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] o, input logic [31:0] e, input string n);
    rexp_t x;
    x.exp = e;
    x.name = n;
    rd_q.push_back(x);
    mb_rd = 1'b1;
    mb_rd_offset = o;
    @(posedge clk); #1;
    mb_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_bus(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
    bus_t x;
    x.wr = w;
    x.addr = a;
    x.data = d;
    bus_q.push_back(x);
  endtask

  typedef struct {logic wr; logic [3:0] off; logic [31:0] data; string name;} vec_t;
  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b0, 4'h0, 32'h0000_0000, "rst_cmd"};
    tbl[1]  = '{1'b0, 4'h4, 32'h0000_0000, "rst_addr"};
    tbl[2]  = '{1'b0, 4'h8, 32'h0000_0000, "rst_rddata"};
    tbl[3]  = '{1'b0, 4'hC, 32'h0000_0000, "rst_wrdata"};
    tbl[4]  = '{1'b1, 4'h4, 32'h1234_5678, ""};
    tbl[5]  = '{1'b0, 4'h4, 32'h0000_5678, "addr_trunc"};
    tbl[6]  = '{1'b1, 4'hC, 32'hDEAD_BEEF, ""};
    tbl[7]  = '{1'b0, 4'hC, 32'hDEAD_BEEF, "wrdata_rw"};
    tbl[8]  = '{1'b1, 4'h8, 32'h0000_0001, ""};
    tbl[9]  = '{1'b0, 4'h8, 32'h0000_0000, "rddata_ro"};
    tbl[10] = '{1'b1, 4'h2, 32'hFFFF_FFFF, ""};
    tbl[11] = '{1'b0, 4'h2, 32'h0000_0000, "unmapped_2"};
    tbl[12] = '{1'b1, 4'h0, 32'h0000_0003, ""};
    tbl[13] = '{1'b0, 4'h0, 32'h0000_0003, "cmd3_noop"};
    tbl[14] = '{1'b1, 4'h0, 32'h0000_0000, ""};
    tbl[15] = '{1'b0, 4'h0, 32'h0000_0000, "cmd0_noop"};
    tbl[16] = '{1'b0, 4'hF, 32'h0000_0000, "unmapped_f"};
    idle(3);
    chk("rst_tc_read", 32'(tc_read), 32'h0);
    chk("rst_tc_write", 32'(tc_write), 32'h0);
    chk("rst_tc_address", 32'(tc_address), 32'h0);
    chk("rst_rd_valid", 32'(mb_rd_valid), 32'h0);
    rst = 1'b0;
    idle(2);
    for (int i = 0; i < 17; i++)
      if (tbl[i].wr) wr(tbl[i].off, tbl[i].data);
      else rd(tbl[i].off, tbl[i].data, tbl[i].name);
    idle(3);
    // write with 3 stall cycles
    wr(4'hC, 32'h10);
    wr(4'h4, 32'h0);
    exp_bus(1'b1, 16'h0, 32'h10);
    wr_stall = 3;
    wr_hi = 0;
    wr(4'h0, 32'd2);
    idle(10);
    chk("wr_hold_cycles", 32'(wr_hi), 32'd4);
    rd(4'h0, 32'h6, "t1_cmd");
    // read with data 5 cycles after accept
    wr_stall = 0;
    rd_lat = 5;
    rd_val = 32'h55;
    wr(4'h4, 32'h101);
    exp_bus(1'b0, 16'h101, 32'h0);
    wr(4'h0, 32'd1);
    idle(12);
    rd(4'h8, 32'h55, "t2_rddata");
    rd(4'h0, 32'h5, "t2_cmd");
    // read that times out
    stuck = 1'b1;
    rd_hi = 0;
    wr(4'h0, 32'd1);
    idle(22);
    chk("rd_timeout_cycles", 32'(rd_hi), 32'd16);
    rd(4'h0, 32'h15, "t3_cmd_err");
    rd(4'h8, 32'hFFFF_FFFF, "t3_rddata");
    stuck = 1'b0;
    exp_bus(1'b1, 16'h101, 32'h10);
    wr(4'h0, 32'd2);
    idle(10);
    rd(4'h0, 32'h6, "t3_err_clr");
    // host writes while busy
    wr_stall = 8;
    exp_bus(1'b1, 16'h101, 32'h10);
    wr(4'h0, 32'd2);
    wr(4'h0, 32'd2);
    wr(4'h4, 32'h200);
    idle(20);
    rd(4'h4, 32'h200, "t4_addr");
    rd(4'h0, 32'h6, "t4_cmd");
    // async reset during a stalled write
    wr_stall = 0;
    stuck = 1'b1;
    wr(4'h0, 32'd2);
    chk("pre_rst_write", 32'(tc_write), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_drops_write", 32'(tc_write), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    stuck = 1'b0;
    idle(3);
    rd(4'h0, 32'h0, "t5_cmd");
    rd(4'h4, 32'h0, "t5_addr");
    idle(5);
    // NOOP commands after a completed op
    wr(4'h4, 32'h2A);
    wr(4'hC, 32'hCAFE);
    exp_bus(1'b1, 16'h2A, 32'hCAFE);
    wr(4'h0, 32'd2);
    idle(6);
    rd(4'h0, 32'h6, "t6_cmd");
    wr(4'h0, 32'd0);
    rd(4'h0, 32'h0, "t6_noop0");
    wr(4'h0, 32'd3);
    idle(5);
    rd(4'h0, 32'h3, "t6_noop3");
    idle(5);
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
